// File: rtl/simon_pkg.sv
// Shared types for the Simon game blocks: colour codes, the round-check FSM states
// and the width of a round index.
`timescale 1ns/1ps
package simon_pkg;

    localparam int ROUND_W = 6;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        VERDICT = 2'd2
    } check_state_t;

endpackage

// File: rtl/seq_store.sv
// Colour sequence register file: append-only writes at seq_len, combinational read,
// synchronous clear of the length (storage contents are left as they are).
`timescale 1ns/1ps
import simon_pkg::*;

module seq_store #(
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  colour_t            wr_colour_i,
    input  logic [ROUND_W-1:0] rd_idx_i,
    output colour_t            rd_colour_o,
    output logic [ROUND_W:0]   len_o,
    output logic               full_o
);

    localparam logic [ROUND_W:0] DEPTH_L = (ROUND_W + 1)'(DEPTH);

    colour_t          mem_q [DEPTH];
    logic [ROUND_W:0] len_q;
    logic [ROUND_W:0] len_d;
    logic             wr_ok;

    assign full_o = (len_q == DEPTH_L);
    assign wr_ok  = wr_en_i && !full_o;

    always_comb begin
        len_d = len_q;
        if (wr_ok) begin
            len_d = len_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    // A write is only possible while not full, so len_q fits the index width here.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr_i) begin
            mem_q[len_q[ROUND_W-1:0]] <= wr_colour_i;
        end
    end

    assign rd_colour_o = mem_q[rd_idx_i];
    assign len_o       = len_q;

endmodule

// File: rtl/sequence_checker.sv
// Round-check responder: records the announced colour sequence and checks the
// player's presses against entries 0..check_round, reporting pass/fail on done.
`timescale 1ns/1ps
import simon_pkg::*;

module sequence_checker #(
    parameter int MAX_ROUNDS     = 64,
    parameter int TIMEOUT_PULSES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               load_colour,
    input  logic [1:0]         colour_in,
    input  logic               player_turn,
    input  logic [ROUND_W-1:0] check_round,
    input  logic               pulse,
    input  logic               btn_valid,
    input  logic [1:0]         btn_colour,
    output logic               result,
    output logic               done,
    output logic [ROUND_W:0]   seq_len,
    output logic               full,
    output check_state_t       state_dbg
);

    localparam int                CNT_W   = $clog2(TIMEOUT_PULSES + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_PULSES - 1);

    check_state_t       state_q, state_d;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic [ROUND_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               result_q, result_d;
    colour_t            rd_colour;
    logic               clear;

    assign clear = rst || start;

    seq_store #(
        .DEPTH (MAX_ROUNDS)
    ) u_store (
        .clk         (clk),
        .clr_i       (clear),
        .wr_en_i     (load_colour && (state_q == IDLE)),
        .wr_colour_i (colour_t'(colour_in)),
        .rd_idx_i    (idx_q),
        .rd_colour_o (rd_colour),
        .len_o       (seq_len),
        .full_o      (full)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        target_d = target_q;
        tcnt_d   = tcnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (player_turn) begin
                    state_d  = CHECK;
                    target_d = check_round;
                    idx_d    = '0;
                    tcnt_d   = '0;
                    result_d = 1'b0;
                end
            end
            CHECK: begin
                // Abort outranks everything; an invalid target fails before any press counts.
                if (!player_turn) begin
                    state_d  = IDLE;
                    result_d = 1'b0;
                end else if ({1'b0, target_q} >= seq_len) begin
                    state_d  = VERDICT;
                    result_d = 1'b0;
                end else if (btn_valid) begin
                    if (btn_colour != rd_colour) begin
                        state_d  = VERDICT;
                        result_d = 1'b0;
                    end else if (idx_q == target_q) begin
                        state_d  = VERDICT;
                        result_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        tcnt_d = '0;
                    end
                end else if (pulse) begin
                    if (tcnt_q == TO_LAST) begin
                        state_d  = VERDICT;
                        result_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            VERDICT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            target_q <= '0;
            tcnt_q   <= '0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            tcnt_q   <= tcnt_d;
            result_q <= result_d;
        end
    end

    assign done      = (state_q == VERDICT);
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: directed scenarios plus randomized rounds
// checked against a queue-based model of the game rules.
`timescale 1ns/1ps
import simon_pkg::*;

module tb_sequence_checker;

    localparam int MAX_ROUNDS     = 64;
    localparam int TIMEOUT_PULSES = 8;

    logic         clk = 1'b0;
    logic         rst, start, load_colour, player_turn, pulse, btn_valid;
    logic [1:0]   colour_in, btn_colour;
    logic [5:0]   check_round;
    logic         result, done, full;
    logic [6:0]   seq_len;
    check_state_t state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the stored colour sequence.
    logic [1:0] exp_q[$];

    sequence_checker #(
        .MAX_ROUNDS     (MAX_ROUNDS),
        .TIMEOUT_PULSES (TIMEOUT_PULSES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_colour (load_colour),
        .colour_in   (colour_in),
        .player_turn (player_turn),
        .check_round (check_round),
        .pulse       (pulse),
        .btn_valid   (btn_valid),
        .btn_colour  (btn_colour),
        .result      (result),
        .done        (done),
        .seq_len     (seq_len),
        .full        (full),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; load_colour = 0; colour_in = 0; player_turn = 0;
        check_round = 0; pulse = 0; btn_valid = 0; btn_colour = 0;
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
        exp_q.delete();
    endtask

    task automatic do_load(input logic [1:0] c);
        load_colour = 1; colour_in = c;
        step();
        load_colour = 0;
        if (exp_q.size() < MAX_ROUNDS) exp_q.push_back(c);
    endtask

    task automatic begin_check(input int r);
        player_turn = 1; check_round = 6'(r);
        step();
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1; btn_colour = c;
        step();
        btn_valid = 0;
    endtask

    task automatic tick();
        pulse = 1;
        step();
        pulse = 0;
    endtask

    task automatic end_check();
        player_turn = 0;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; step(); step(); rst = 0;
        exp_q.delete();
        n_checks++; if (result !== 1'b0) begin n_fail++; $display("FAIL reset_result: got %b want 0", result); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (seq_len !== 7'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", seq_len); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_pass();
        do_start();
        do_load(RED); do_load(GREEN); do_load(BLUE);
        n_checks++; if (seq_len !== 7'd3) begin n_fail++; $display("FAIL pass_len: got %0d want 3", seq_len); end
        begin_check(2);
        n_checks++; if (state_dbg !== CHECK) begin n_fail++; $display("FAIL pass_enter: got %0d want CHECK", state_dbg); end
        press(RED);
        press(GREEN);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL pass_early_done: got %b want 0", done); end
        press(BLUE);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pass_done: got %b want 1", done); end
        n_checks++; if (result !== 1'b1) begin n_fail++; $display("FAIL pass_result: got %b want 1", result); end
        end_check();
        n_checks++; if (done !== 1'b0 || state_dbg !== IDLE) begin
            n_fail++; $display("FAIL pass_after: done=%b state=%0d want 0/IDLE", done, state_dbg); end
        n_checks++; if (result !== 1'b1) begin n_fail++; $display("FAIL pass_hold: got %b want 1", result); end
    endtask

    task automatic test_mismatch();
        do_start();
        do_load(RED); do_load(GREEN); do_load(BLUE);
        begin_check(2);
        n_checks++; if (result !== 1'b0) begin n_fail++; $display("FAIL mm_cleared: got %b want 0", result); end
        press(RED);
        press(YELLOW);
        n_checks++; if (done !== 1'b1 || result !== 1'b0) begin
            n_fail++; $display("FAIL mm_verdict: done=%b result=%b want 1/0", done, result); end
        player_turn = 0;
        press(BLUE);
        n_checks++; if (done !== 1'b0 || state_dbg !== IDLE) begin
            n_fail++; $display("FAIL mm_ignore: done=%b state=%0d want 0/IDLE", done, state_dbg); end
        press(GREEN);
        n_checks++; if (done !== 1'b0 || result !== 1'b0) begin
            n_fail++; $display("FAIL mm_ignore2: done=%b result=%b want 0/0", done, result); end
    endtask

    task automatic test_timeout();
        do_start();
        do_load(RED); do_load(GREEN); do_load(BLUE);
        begin_check(2);
        press(RED);
        for (int i = 0; i < TIMEOUT_PULSES - 1; i++) begin
            tick();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL to_early_%0d: got %b want 0", i, done); end
        end
        press(GREEN);
        n_checks++; if (done !== 1'b0 || state_dbg !== CHECK) begin
            n_fail++; $display("FAIL to_press: done=%b state=%0d want 0/CHECK", done, state_dbg); end
        for (int i = 0; i < TIMEOUT_PULSES - 1; i++) begin
            tick();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL to_reset_%0d: got %b want 0", i, done); end
        end
        tick();
        n_checks++; if (done !== 1'b1 || result !== 1'b0) begin
            n_fail++; $display("FAIL to_verdict: done=%b result=%b want 1/0", done, result); end
        end_check();
    endtask

    task automatic test_invalid_target();
        do_start();
        do_load(RED); do_load(GREEN);
        begin_check(3);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL inv_n1: got %b want 0", done); end
        step();
        n_checks++; if (done !== 1'b1 || result !== 1'b0) begin
            n_fail++; $display("FAIL inv_n2: done=%b result=%b want 1/0", done, result); end
        end_check();
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL inv_idle: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_full();
        do_start();
        for (int i = 0; i < MAX_ROUNDS - 1; i++) do_load(2'($urandom_range(0, 3)));
        n_checks++; if (seq_len !== 7'(MAX_ROUNDS - 1) || full !== 1'b0) begin
            n_fail++; $display("FAIL full_63: len=%0d full=%b want %0d/0", seq_len, full, MAX_ROUNDS - 1); end
        do_load(YELLOW);
        n_checks++; if (seq_len !== 7'(MAX_ROUNDS) || full !== 1'b1) begin
            n_fail++; $display("FAIL full_64: len=%0d full=%b want %0d/1", seq_len, full, MAX_ROUNDS); end
        do_load(RED);
        n_checks++; if (seq_len !== 7'(MAX_ROUNDS) || full !== 1'b1) begin
            n_fail++; $display("FAIL full_65: len=%0d full=%b want %0d/1", seq_len, full, MAX_ROUNDS); end
        // Last entry must still be the 64th colour, not the ignored 65th.
        begin_check(MAX_ROUNDS - 1);
        for (int i = 0; i < MAX_ROUNDS; i++) press(exp_q[i]);
        n_checks++; if (done !== 1'b1 || result !== 1'b1) begin
            n_fail++; $display("FAIL full_check: done=%b result=%b want 1/1", done, result); end
        end_check();
    endtask

    task automatic test_abort();
        do_start();
        do_load(BLUE); do_load(RED); do_load(GREEN);
        begin_check(2);
        press(BLUE); press(RED); press(GREEN);
        end_check();
        begin_check(2);
        n_checks++; if (result !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got %b want 0", result); end
        press(BLUE);
        player_turn = 0;
        press(RED);
        n_checks++; if (state_dbg !== IDLE || done !== 1'b0 || result !== 1'b0) begin
            n_fail++; $display("FAIL abort: state=%0d done=%b result=%b want IDLE/0/0", state_dbg, done, result); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_nodone: got %b want 0", done); end
    endtask

    task automatic test_start_mid_check();
        do_start();
        do_load(RED); do_load(GREEN);
        begin_check(1);
        press(RED);
        start = 1; player_turn = 0;
        step();
        start = 0;
        exp_q.delete();
        n_checks++; if (seq_len !== 7'd0 || state_dbg !== IDLE || done !== 1'b0) begin
            n_fail++; $display("FAIL start_mid: len=%0d state=%0d done=%b want 0/IDLE/0", seq_len, state_dbg, done); end
        do_load(YELLOW);
        rst = 1; step(); rst = 0;
        exp_q.delete();
        n_checks++; if (seq_len !== 7'd0) begin n_fail++; $display("FAIL rst_len: got %0d want 0", seq_len); end
    endtask

    task automatic test_simultaneous();
        do_start();
        do_load(RED); do_load(GREEN); do_load(BLUE);
        begin_check(2);
        for (int i = 0; i < TIMEOUT_PULSES - 1; i++) tick();
        pulse = 1;
        press(RED);
        pulse = 0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL sim_press: got %b want 0", done); end
        for (int i = 0; i < TIMEOUT_PULSES - 1; i++) tick();
        n_checks++; if (done !== 1'b0 || state_dbg !== CHECK) begin
            n_fail++; $display("FAIL sim_count: done=%b state=%0d want 0/CHECK", done, state_dbg); end
        load_colour = 1; colour_in = YELLOW;
        step();
        load_colour = 0;
        n_checks++; if (seq_len !== 7'd3) begin n_fail++; $display("FAIL sim_load: got %0d want 3", seq_len); end
        press(GREEN); press(BLUE);
        n_checks++; if (done !== 1'b1 || result !== 1'b1) begin
            n_fail++; $display("FAIL sim_pass: done=%b result=%b want 1/1", done, result); end
        end_check();
    endtask

    // Random rounds: the model walks the player's events through the game rules.
    task automatic test_random();
        int len, tgt, pos, cnt, guard, pulse_weight;
        bit decided, exp_pass, is_pulse;
        logic [1:0] c;
        for (int it = 0; it < 30; it++) begin
            do_start();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) do_load(2'($urandom_range(0, 3)));
            tgt = ($urandom_range(0, 4) == 0) ? $urandom_range(len, len + 3) : $urandom_range(0, len - 1);
            pulse_weight = ($urandom_range(0, 2) == 0) ? 8 : 2;
            begin_check(tgt);
            if (tgt >= exp_q.size()) begin
                step();
                n_checks++; if (done !== 1'b1 || result !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_inv_%0d: done=%b result=%b want 1/0", it, done, result); end
                end_check();
                continue;
            end
            pos = 0; cnt = 0; decided = 0; exp_pass = 0; guard = 0;
            while (!decided && guard < 400) begin
                guard++;
                if ($urandom_range(0, 3) == 0) begin
                    step();
                    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rnd_gap_%0d: got %b want 0", it, done); end
                end
                is_pulse = ($urandom_range(0, 9) < pulse_weight);
                if (is_pulse) begin
                    tick();
                    cnt++;
                    if (cnt == TIMEOUT_PULSES) begin decided = 1; exp_pass = 0; end
                end else begin
                    c = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(0, 3)) : exp_q[pos];
                    press(c);
                    if (c != exp_q[pos]) begin decided = 1; exp_pass = 0; end
                    else if (pos == tgt) begin decided = 1; exp_pass = 1; end
                    else begin pos++; cnt = 0; end
                end
                n_checks++; if (done !== decided) begin
                    n_fail++; $display("FAIL rnd_done_%0d: got %b want %b", it, done, decided); end
            end
            n_checks++; if (!decided || result !== exp_pass) begin
                n_fail++; $display("FAIL rnd_result_%0d: got %b want %b decided=%b", it, result, exp_pass, decided); end
            end_check();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_invalid_target();
        test_full();
        test_abort();
        test_start_mid_check();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Responder for the game FSM's round-check command. It records the colour sequence as the FSM announces each new colour and verifies the player's button presses against that stored sequence. It then returns a pass/fail verdict to the FSM through `result`. It sits between the FSM, the button debouncers and the flash timer's `pulse`.

## Interface
Parameters:
- `MAX_ROUNDS`, default 64: sequence storage depth; must be ≤ 64 to match 6-bit `check_round`.
- `TIMEOUT_PULSES`, default 8: `pulse` ticks allowed between player presses before a forced fail.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: new game; clears the sequence and the verdict.
- `load_colour` in 1: append `colour_in` to the sequence.
- `colour_in` in 2: colour code announced by the FSM.
- `player_turn` in 1: level; high while the player is entering the sequence.
- `check_round` in 6: index of the last entry to check; entries 0..`check_round` are compared.
- `pulse` in 1: one-cycle tick from the flash timer.
- `btn_valid` in 1: one-cycle strobe, one per debounced press.
- `btn_colour` in 2: colour of the pressed button.
- `result` out 1: 1 = last check passed, 0 = failed, aborted or none yet.
- `done` out 1: one-cycle strobe marking the check verdict.
- `seq_len` out 7: number of stored entries, 0..`MAX_ROUNDS`.
- `full` out 1: `seq_len == MAX_ROUNDS`.

## Operation
- States are IDLE, CHECK, VERDICT.
- Priority order is `rst`, then `start`, then everything else.
- `rst` or `start` clears the following: state→IDLE, `seq_len`=0, `result`=0, `done`=0, index=0, timeout count=0. Storage contents are don't-care.
- **`load_colour`**
  - Accepted only in IDLE with `full`=0: `mem[seq_len]`←`colour_in`, `seq_len`++.
  - When full, the load is ignored and `seq_len` holds at `MAX_ROUNDS`.
  - In CHECK or VERDICT, the load is ignored.
- **IDLE→CHECK** occurs on the first cycle `player_turn`=1. On that transition:
  - latch target←`check_round`;
  - index←0;
  - timeout count←0;
  - `result`←0.
- **Invalid target:** if the latched target ≥ `seq_len`, the next state is VERDICT with fail.
- **CHECK, `btn_valid`=1:**
  - If `btn_colour` ≠ `mem[index]`, go to VERDICT with fail.
  - Else, if index == target, go to VERDICT with pass.
  - Else, index++ and timeout count←0.
- **CHECK, `pulse`=1 with no `btn_valid` that cycle:** timeout count++. When it reaches `TIMEOUT_PULSES`, go to VERDICT with fail. A press and a pulse in the same cycle: the press wins and the count resets.
- **CHECK, `player_turn`=0:** abort to IDLE. `result`=0, no `done`. A simultaneous `btn_valid` is discarded.
- **VERDICT** lasts exactly one cycle:
  - `done`=1;
  - `result` is registered as 1 for pass or 0 for fail and holds until the next IDLE→CHECK, `start` or `rst`;
  - next state is IDLE.
- **Re-check:** if `player_turn` is still high when IDLE is re-entered, a new check starts the next cycle. The FSM must drop `player_turn` on `done`.
- `btn_valid` is ignored outside CHECK.

## Timing
- Reset values: `result`=0, `done`=0, `seq_len`=0, `full`=0.
- `load_colour` at cycle n → `seq_len` is updated at n+1.
- `player_turn` first high at n → CHECK at n+1. Presses are accepted from n+1.
- Final-deciding press, mismatch or timeout pulse at cycle n:
  - `done`=1 and `result` valid at n+1;
  - IDLE at n+2.
- Invalid target: `player_turn` rising at n → `done` at n+2 with `result`=0.
- Storage read is combinational from the index. The comparison happens in the press cycle, with no read latency.

## Structure
- Package `simon_pkg` holds:
  - `colour_t` (2-bit enum: RED=0, GREEN=1, BLUE=2, YELLOW=3);
  - `check_state_t`;
  - `ROUND_W`=6.
- Sub-module `seq_store` holds the MAX_ROUNDS×2 register file, the write pointer, `seq_len`, `full`, a combinational read port and synchronous clear.
- The top level holds the FSM, the index/target registers and the timeout counter.

## Test plan
1. **Pass:** `start`, load RED, GREEN, BLUE, `check_round`=2, press RED, GREEN, BLUE → `done` one cycle after BLUE, `result`=1.
2. **Mismatch:** same sequence, press RED then YELLOW → `done`/`result`=0 one cycle after YELLOW. Further presses are ignored.
3. **Timeout:** `TIMEOUT_PULSES`=8, one press then 8 `pulse` ticks → fail on the cycle after the 8th tick. 7 ticks then a press resets the count.
4. **Invalid target and full:**
   - `check_round`=3 with `seq_len`=2 → `result`=0, `done` at n+2.
   - 65 loads → `seq_len`=64, `full`=1, 65th load ignored.
5. **Abort and reset mid-check:**
   - `player_turn` drops mid-CHECK → IDLE, no `done`, `result`=0.
   - `start` during CHECK → `seq_len`=0, IDLE.
6. **Simultaneous events:**
   - `btn_valid` and `pulse` in the same cycle → press processed, timeout count 0.
   - `load_colour` during CHECK → `seq_len` unchanged.
